// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan sequencer and its helpers.
package mux_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  // Literals carry a prefix so they cannot collide with the SETTLE parameter.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mux_scan_seq_if.sv
// Bundle of the request, mux-side and result handshake signals of the scanner.
interface mux_scan_seq_if;
  import mux_scan_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] chan_mask;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic [NUM_CH-1:0] data;
  logic              valid;
  logic              ready;
  logic              busy;

  // Requester / mux / downstream side.
  modport master (
    output start, chan_mask, mux_out, ready,
    input  sel, data, valid, busy
  );

  // Sequencer side.
  modport slave (
    input  start, chan_mask, mux_out, ready,
    output sel, data, valid, busy
  );

endinterface

// File: rtl/mux_scan_next_ch.sv
// Finds the next enabled channel above cur, or the lowest enabled one when first is set.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  // Priority search from the top down so the lowest qualifying channel wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise the
    // no-match path would leave them unassigned and infer latches.
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (SEL_W'(i) > cur))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Steps an 8:1 mux through the enabled channels, waits SETTLE cycles on each,
// samples the returned bit and hands the packed byte downstream on valid/ready.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_scan_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0] mask_q;
  logic [SEL_W-1:0]  sel_q;
  logic [NUM_CH-1:0] data_q;
  logic              valid_q;

  logic [NUM_CH-1:0] search_mask;
  logic              search_first;
  logic [SEL_W-1:0]  nxt_ch;
  logic              nxt_found;

  // In IDLE the search runs on the live mask being captured; afterwards on mask_q.
  always_comb begin
    search_first = (state == ST_IDLE);
    search_mask  = search_first ? bus.chan_mask : mask_q;
  end

  mux_scan_next_ch u_next_ch (
    .mask  (search_mask),
    .cur   (sel_q),
    .first (search_first),
    .nxt   (nxt_ch),
    .found (nxt_found)
  );

  // Scan FSM: all outputs are registered here so nothing from the inputs reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state, sel_q and cnt regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mask_q <= bus.chan_mask;
            data_q <= '0;
            if (nxt_found) begin
              sel_q <= nxt_ch;
              cnt   <= CNT_LOAD;
              state <= ST_SETTLE;
            end else begin
              valid_q <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SAMPLE: begin
          data_q[sel_q] <= bus.mux_out;
          if (nxt_found) begin
            sel_q <= nxt_ch;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end else begin
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (valid_q && bus.ready) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq: table of scans plus hand-written corner sequences.
module tb_mux_scan_seq;

  localparam int SETTLE_TB = 1;
  localparam int TIMEOUT   = 200;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] pattern;
    int         ready_wait;
    logic [7:0] exp_data;
    string      name;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [7:0] pattern;

  int n_cmp;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [2:0] trace[$];
  vec_t       vecs[8];

  mux_scan_seq_if bus ();

  // Model of the 8:1 mux: returns the selected bit of the current input pattern.
  assign bus.mux_out = pattern[bus.sel];

  mux_scan_seq #(
    .SETTLE (SETTLE_TB),
    .CNT_W  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for valid, recording sel each cycle; optionally pokes start/chan_mask mid-scan.
  task automatic wait_valid(input int disturb_at, output int cyc);
    cyc = 0;
    trace.delete();
    while (bus.valid !== 1'b1 && cyc < TIMEOUT) begin
      trace.push_back(bus.sel);
      if (cyc == disturb_at) begin
        bus.start     = 1'b1;
        bus.chan_mask = 8'h0F;
      end
      if (cyc == disturb_at + 2) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  // Expected sel sequence: each enabled channel ascending, held SETTLE+1 cycles.
  task automatic check_trace(input logic [7:0] mask, input string name);
    int idx = 0;
    int bad = 0;
    for (int ch = 0; ch < 8; ch++) begin
      if (mask[ch]) begin
        for (int r = 0; r <= SETTLE_TB; r++) begin
          if (idx >= trace.size() || trace[idx] !== 3'(ch)) bad++;
          idx++;
        end
      end
    end
    check({name, "_sel_len"}, trace.size(), idx);
    check({name, "_sel_seq"}, bad, 0);
  endtask

  // Completes the handshake at the current negedge (ready already high).
  task automatic handshake(input string name);
    logic [7:0] exp;
    check({name, "_valid"}, bus.valid, 1'b1);
    if (exp_q.size() == 0) begin
      check({name, "_sb_nonempty"}, 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_data"}, bus.data, exp);
    end
    @(negedge clk);
    check({name, "_valid_drop"}, bus.valid, 1'b0);
    check({name, "_busy_drop"}, bus.busy, 1'b0);
  endtask

  task automatic do_scan(input vec_t v, input int disturb_at);
    int cyc;
    exp_q.push_back(v.exp_data);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.chan_mask = v.mask;
    pattern       = v.pattern;
    bus.ready     = (v.ready_wait == 0);
    @(negedge clk);
    bus.start = 1'b0;
    check({v.name, "_busy"}, bus.busy, 1'b1);
    wait_valid(disturb_at, cyc);
    check({v.name, "_latency"}, cyc, $countones(v.mask) * (SETTLE_TB + 1));
    check_trace(v.mask, v.name);
    for (int k = 0; k < v.ready_wait; k++) begin
      check({v.name, "_hold_valid"}, bus.valid, 1'b1);
      check({v.name, "_hold_data"}, bus.data, v.exp_data);
      @(negedge clk);
    end
    bus.ready = 1'b1;
    handshake(v.name);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    logic [7:0] tmp;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{8'h00, 8'hA5, 0, 8'h00, "empty"};
    vecs[1] = '{8'hFF, 8'hA5, 0, 8'hA5, "full"};
    vecs[2] = '{8'h81, 8'hFF, 0, 8'h81, "sparse"};
    vecs[3] = '{8'hFF, 8'hA5, 5, 8'hA5, "backpressure"};
    vecs[4] = '{8'h5A, 8'h3C, 2, 8'h18, "mixed"};
    vecs[5] = '{8'h80, 8'hFF, 0, 8'h80, "top_only"};
    vecs[6] = '{8'h01, 8'h00, 1, 8'h00, "low_zero"};
    vecs[7] = '{8'h66, 8'hFF, 0, 8'h66, "pairs"};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.chan_mask = 8'h00;
    bus.ready     = 1'b1;
    pattern       = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_sel", bus.sel, 3'd0);
    check("rst_data", bus.data, 8'h00);
    check("rst_valid", bus.valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of scans; the empty one runs first so sel is still at its reset value.
    for (int i = 0; i < 8; i++) begin
      do_scan(vecs[i], -1);
      if (i == 0) check("empty_sel_stays", bus.sel, 3'd0);
    end

    // start pulsed and chan_mask changed mid-scan must be ignored.
    do_scan(vecs[1], 3);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.busy || bus.valid) busy_cnt++;
    end
    check("ignored_no_second_scan", busy_cnt, 0);

    // start together with ready in DONE is only taken from IDLE on the next edge.
    exp_q.push_back(8'hA5);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.chan_mask = 8'hFF;
    pattern       = 8'hA5;
    bus.ready     = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(-1, cyc);
    check("done_start_latency", cyc, 16);
    bus.ready     = 1'b1;
    bus.start     = 1'b1;
    bus.chan_mask = 8'h01;
    check("done_start_valid", bus.valid, 1'b1);
    tmp = exp_q.pop_front();
    check("done_start_data", bus.data, tmp);
    @(negedge clk);
    check("done_start_not_taken_busy", bus.busy, 1'b0);
    check("done_start_not_taken_valid", bus.valid, 1'b0);
    exp_q.push_back(8'h01);
    @(negedge clk);
    bus.start = 1'b0;
    check("done_start_taken_busy", bus.busy, 1'b1);
    wait_valid(-1, cyc);
    check("second_scan_latency", cyc, 2);
    handshake("second_scan");

    // Asynchronous reset while channel 3 is being sampled.
    exp_q.push_back(8'hA5);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.chan_mask = 8'hFF;
    pattern       = 8'hA5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_sel", bus.sel, 3'd3);
    check("pre_reset_partial", bus.data, 8'h05);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_sel", bus.sel, 3'd0);
    check("async_rst_valid", bus.valid, 1'b0);
    check("async_rst_busy", bus.busy, 1'b0);
    check("async_rst_data", bus.data, 8'h00);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    do_scan('{8'hFF, 8'h3C, 0, 8'h3C, "after_reset"}, -1);

    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Sequencer that sits directly upstream of the team's 8:1 single-bit channel mux.
- Drives the mux select, waits a programmable settle time, then samples the mux output bit on each enabled channel in ascending order.
- Packs the eight results into one byte and presents it downstream on a valid/ready handshake.
- Used wherever eight status/sense lines share one mux and must be read as a single word.

Parameters:
- SETTLE, 1: cycles sel is held stable on a channel before its bit is sampled; legal range 1..15.
- CNT_W, 4: width of the settle counter; must hold SETTLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request one scan; sampled only in IDLE
- chan_mask  input  8  channel enable, bit i = channel i; captured when start is accepted
- sel  output  3  select to the 8:1 mux
- mux_out  input  1  bit returned by the mux for the current sel
- data  output  8  assembled scan result, bit i = channel i
- valid  output  1  data available downstream
- ready  input  1  downstream accepts data
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - state = IDLE, sel = 0, data = 0, valid = 0, busy = 0.
  - Settle counter = 0, captured mask = 0.
- A reset mid-scan or mid-DONE aborts immediately; there is no partial result and no valid.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On an edge with start = 1, capture chan_mask into mask_q and clear data to 0.
  - If mask_q != 0: load sel with the lowest enabled channel, load counter = SETTLE-1, go to SETTLE.
  - If mask_q == 0: go straight to DONE; data = 0, valid = 1 on the next cycle.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to SAMPLE. This gives exactly SETTLE cycles in SETTLE per channel.
- SAMPLE (one cycle):
  - At the end of the cycle, data[sel] <= mux_out.
  - If a higher enabled channel exists in mask_q: sel <= that channel, counter <= SETTLE-1, go to SETTLE.
  - Otherwise go to DONE.
- DONE:
  - valid = 1; data and sel are held stable.
  - On an edge with valid && ready, go to IDLE and deassert valid. sel holds its last value; data is held until the next accepted start.
- Latency:
  - With N enabled channels, valid rises N*(SETTLE+1) cycles after the edge that accepted start.
  - Full mask with SETTLE = 1: valid rises 16 cycles after start.
- Disabled channels:
  - Never selected and never sampled; their data bits read 0.
  - The next-channel search skips gaps (mask 8'b1000_0001 visits sel 0 then sel 7).
- start while busy is ignored; there is no queueing.
- chan_mask changes during a scan have no effect, because mask_q is used.
- ready while valid = 0 has no effect.
- In DONE, a start asserted in the same cycle as ready is not accepted; it is only seen from IDLE on the following edge.
- sel changes only on the IDLE->SETTLE and SAMPLE->SETTLE transitions. It never changes in the cycle mux_out is sampled.
- Outputs are registered; there is no combinational path from the inputs to sel, data or valid.

Decomposition:
- Shared package mux_scan_pkg:
  - State enum (IDLE, SETTLE, SAMPLE, DONE).
  - NUM_CH = 8, SEL_W = 3.
- Sub-module mux_scan_next_ch (combinational):
  - Inputs: mask[7:0], cur[2:0], first.
  - Outputs: nxt[2:0] = lowest enabled channel greater than cur (or lowest overall when first = 1), and found flag.
  - Instantiated once; shared by the IDLE and SAMPLE transitions.

Test Plan:
- Full scan: SETTLE = 1, mask 8'hFF, mux model returns in = 8'hA5 indexed by sel, ready held high.
  - Required: sel steps 0..7, each held 2 cycles; valid rises 16 cycles after start; data = 8'hA5; valid is high for one cycle.
- Sparse mask: mask 8'b1000_0001, in = 8'hFF.
  - Required: only sel 0 and 7 are driven; data = 8'h81; valid rises 4 cycles after start.
- Empty mask: mask 8'h00, start.
  - Required: valid rises 1 cycle after start; data = 8'h00; sel stays 0.
- Backpressure: full scan with ready = 0 for 5 cycles after valid, then 1.
  - Required: valid and data = 8'hA5 held for all 5 cycles; valid drops the cycle after ready is high; busy drops with it.
- Ignored inputs:
  - start pulsed and chan_mask changed to 8'h0F mid-scan.
  - Required: scan completes with the original mask and result; there is no second scan.
- Async reset at SAMPLE of channel 3.
  - Required: sel = 0, valid = 0, busy = 0, data = 0 immediately, without waiting for a clock edge.
  - A new start then gives a correct full result.
